data_memory_ctrl: RTL
=====================

Name: data_memory_ctrl

Overview:
- Synchronous, parameterised data memory for the RISC pipeline's memory stage.
- Replaces the level-triggered 16-bit store with a clocked one-request-at-a-time engine, using a valid/ready request and a one-cycle response pulse.
- Supports single-word and double-word accesses; a double-word is issued as two sequential word accesses (used for PC/flag push and pop).
- Flags out-of-range addresses instead of silently aliasing them.

Parameters:
- DATA_WIDTH, 16: memory word width in bits.
- DEPTH, 2048: number of words; legal word addresses are 0..DEPTH-1.
- ERR_FILL, all-ones (DATA_WIDTH bits): value driven on each rsp_data half on an address error.

Ports:
- clk  in  1: rising-edge clock.
- rst  in  1: synchronous, active-high reset.
- req_valid  in  1: request present.
- req_ready  out  1: block can accept a request.
- req_write  in  1: 1 = write, 0 = read.
- req_double  in  1: 1 = double-word access, 0 = single-word access.
- req_addr  in  32: word address.
- wr_data  in  2*DATA_WIDTH: write data; single-word writes use the low half only.
- rsp_valid  out  1: one-cycle completion pulse.
- rsp_data  out  2*DATA_WIDTH: read data.
- addr_err  out  1: qualifies rsp_valid; request was rejected.

Behaviour:
- Reset (synchronous, active-high, on clk):
  - rst=1 at an edge forces: state=IDLE, rsp_valid=0, rsp_data=0, addr_err=0.
  - req_ready=0 while rst=1.
  - Memory contents are not cleared.
- FSM states:
  - IDLE: req_ready=1.
  - ACC0: access the word at A.
  - ACC1: access the word at A+1 (double-word only).
- Accept:
  - A request is taken at edge E0 where state=IDLE and req_valid=1 and rst=0.
  - req_write, req_double, req_addr (A) and wr_data are registered at E0; input changes after E0 are ignored.
  - req_ready=0 in ACC0 and ACC1; req_valid in those states has no effect.
- Address check (done at accept):
  - Error if A >= DEPTH, or if req_double=1 and A = DEPTH-1.
  - On error: ACC0 performs no memory access, then goes to IDLE.
  - The response carries addr_err=1 and rsp_data={ERR_FILL,ERR_FILL}.
- Word order for double-word accesses: mem[A] holds the high half, mem[A+1] holds the low half.
  - Write: mem[A]<=wr_data[2W-1:W] at E1, mem[A+1]<=wr_data[W-1:0] at E2.
  - Read: rsp_data={mem[A],mem[A+1]}.
- Single-word accesses:
  - Write: mem[A]<=wr_data[W-1:0] at E1.
  - Read: rsp_data={W'b0,mem[A]}.
- Timing:
  - ACC0 occupies edge E1.
  - Single-word or error: IDLE after E1; rsp_valid=1 for the cycle following E1.
  - Double-word: ACC1 occupies E2; IDLE after E2; rsp_valid=1 for the cycle following E2.
  - Latency from accept to response is 1 cycle for single-word/error and 2 cycles for double-word.
  - rsp_valid is asserted in the same cycle that req_ready returns to 1, so a new request can be accepted on the edge that ends the response cycle. Back-to-back single-word throughput is one request per 2 cycles.
- Response:
  - rsp_valid is a single-cycle pulse; there is no response backpressure.
  - Write responses: rsp_data=0, addr_err=0 unless the address check failed.
  - rsp_data and addr_err hold their values until the next response and are meaningful only when rsp_valid=1.
- Read-after-write: a read accepted on the edge that ends a write's response cycle sees the new data.
- Reset during an operation:
  - The operation is aborted and no response is generated.
  - For a double write, a word already written at E1 remains written; the second word is not written.
- Address width: only the low bits of req_addr needed to index DEPTH are used for indexing, after the range check has passed on the full 32 bits.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req_valid=1 -> req_ready=0, rsp_valid=0, rsp_data=0, no write occurs. Release rst -> req_ready=1 in the next cycle.
- Single write then read:
  - Write A=5, wr_data=0x0000_BEEF -> rsp_valid 1 cycle after accept, addr_err=0.
  - Read A=5 -> rsp_data=0x0000_BEEF, 1-cycle latency.
- Double write then reads:
  - Double write A=0x100, wr_data=0x1234_5678 -> rsp 2 cycles after accept.
  - Single read 0x100 -> 0x0000_1234; single read 0x101 -> 0x0000_5678.
  - Double read 0x100 -> 0x1234_5678.
- Errors:
  - Read A=2048 -> rsp_valid with addr_err=1 and rsp_data=0xFFFF_FFFF.
  - Double write A=2047 -> addr_err=1, and mem[2047] is unchanged on readback.
  - Write A=0x0001_0005 -> addr_err=1, and mem[5] is unchanged.
- Busy handling:
  - Assert req_valid continuously during a double read -> req_ready=0 in ACC0/ACC1; exactly one response per accepted request; the request is accepted on the edge that ends the response cycle.
- Reset mid-operation:
  - Double write A=10, data 0xAAAA_5555, with rst=1 at E2 -> no rsp_valid.
  - Reads afterwards give mem[10]=0xAAAA and mem[11] at its prior value.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Clocked data memory for the memory stage: one request at a time over valid/ready,
// single- or double-word access, with a one-cycle response pulse and address-error reporting.
module data_memory_ctrl #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    DEPTH      = 2048,
    parameter logic [DATA_WIDTH-1:0] ERR_FILL   = '1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic                      req_double,
    input  logic [31:0]               req_addr,
    input  logic [2*DATA_WIDTH-1:0]   wr_data,
    output logic                      rsp_valid,
    output logic [2*DATA_WIDTH-1:0]   rsp_data,
    output logic                      addr_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1} state_t;

    state_t              r_state, w_next;
    logic [DW-1:0]       r_mem [DEPTH];

    logic                r_write, r_double, r_err;
    logic [AW-1:0]       r_addr;
    logic [2*DW-1:0]     r_wdata;
    logic [DW-1:0]       r_hi;

    logic                r_rsp_valid, r_addr_err;
    logic [2*DW-1:0]     r_rsp_data;

    logic                w_accept, w_req_err, w_mem_we;
    logic [AW-1:0]       w_idx;
    logic [DW-1:0]       w_mem_wdata, w_rd_word;

    assign w_accept  = (r_state == IDLE) && req_valid && !rst;
    // Range check uses the full 32-bit address so high bits never alias into the array.
    assign w_req_err = (req_addr >= 32'(DEPTH)) ||
                       (req_double && (req_addr == 32'(DEPTH - 1)));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = ACC0;
            ACC0:    w_next = (!r_err && r_double) ? ACC1 : IDLE;
            ACC1:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (r_state == IDLE) && !rst;
        w_mem_we    = 1'b0;
        w_idx       = r_addr;
        w_mem_wdata = r_wdata[DW-1:0];
        case (r_state)
            ACC0: begin
                w_mem_we = r_write && !r_err;
                if (r_double) w_mem_wdata = r_wdata[2*DW-1:DW];
            end
            ACC1: begin
                w_idx    = r_addr + AW'(1);
                w_mem_we = r_write;
            end
            default: ;
        endcase
    end

    assign w_rd_word = r_mem[w_idx];

    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) r_mem[w_idx] <= w_mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write  <= req_write;
            r_double <= req_double;
            r_addr   <= req_addr[AW-1:0];
            r_wdata  <= wr_data;
            r_err    <= w_req_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_addr_err  <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ACC0: begin
                    if (r_err) begin
                        r_rsp_valid <= 1'b1;
                        r_addr_err  <= 1'b1;
                        r_rsp_data  <= {ERR_FILL, ERR_FILL};
                    end else if (!r_double) begin
                        r_rsp_valid <= 1'b1;
                        r_addr_err  <= 1'b0;
                        r_rsp_data  <= r_write ? '0 : {{DW{1'b0}}, w_rd_word};
                    end else if (!r_write) begin
                        r_hi <= w_rd_word;
                    end
                end
                ACC1: begin
                    r_rsp_valid <= 1'b1;
                    r_addr_err  <= 1'b0;
                    r_rsp_data  <= r_write ? '0 : {r_hi, w_rd_word};
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign addr_err  = r_addr_err;

endmodule
